control_sequencer: RTL

Hard-wired control unit for the 32-bit RISC datapath. It produces the Gra/Grb/Grc, Rin/Rout/BAout and Cout strobes consumed by the register select-and-encode logic, plus all other datapath, memory and I/O strobes. It sequences fetch (T0–T2) and execute (T3–T7) per opcode in IR[31:27]. It sits between IR and the datapath, one per CPU.

---
 rtl/control_sequencer_pkg.sv | 100 ++++++++++
 rtl/control_sequencer_output_decode.sv | 150 +++++++++++++++
 rtl/control_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hard-wired control sequencer: opcode values,
// FSM state encoding, the strobe bundle and the per-opcode final step.
package control_sequencer_pkg;

   localparam int OPC_W   = 5;
   localparam int ALUOP_W = 5;

   // Opcode field position inside the instruction register
   localparam int IR_OPC_MSB = 31;
   localparam int IR_OPC_LSB = 27;

   localparam logic [OPC_W-1:0] OP_LD   = 5'd0;
   localparam logic [OPC_W-1:0] OP_LDI  = 5'd1;
   localparam logic [OPC_W-1:0] OP_ST   = 5'd2;
   localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
   localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
   localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'd7;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'd8;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'd9;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'd10;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'd11;
   localparam logic [OPC_W-1:0] OP_ANDI = 5'd12;
   localparam logic [OPC_W-1:0] OP_ORI  = 5'd13;
   localparam logic [OPC_W-1:0] OP_MUL  = 5'd14;
   localparam logic [OPC_W-1:0] OP_DIV  = 5'd15;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'd16;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'd17;
   localparam logic [OPC_W-1:0] OP_BR   = 5'd18;
   localparam logic [OPC_W-1:0] OP_JR   = 5'd19;
   localparam logic [OPC_W-1:0] OP_JAL  = 5'd20;
   localparam logic [OPC_W-1:0] OP_IN   = 5'd21;
   localparam logic [OPC_W-1:0] OP_OUT  = 5'd22;
   localparam logic [OPC_W-1:0] OP_MFHI = 5'd23;
   localparam logic [OPC_W-1:0] OP_MFLO = 5'd24;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'd25;
   localparam logic [OPC_W-1:0] OP_HALT = 5'd26;

   // RST/HALT/WAIT are the only states with Run=0
   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_F0   = 4'd1,
      S_F1   = 4'd2,
      S_F2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_T7   = 4'd8,
      S_HALT = 4'd9,
      S_WAIT = 4'd10
   } state_e;

   // Every strobe the sequencer drives, plus the ALU operation code
   typedef struct packed {
      logic               run;
      logic               pc_out;
      logic               inc_pc;
      logic               pc_in;
      logic               mar_in;
      logic               mdr_in;
      logic               mdr_out;
      logic               read;
      logic               write;
      logic               ir_in;
      logic               y_in;
      logic               z_in;
      logic               z_low_out;
      logic               z_high_out;
      logic               hi_in;
      logic               lo_in;
      logic               hi_out;
      logic               lo_out;
      logic               gra;
      logic               grb;
      logic               grc;
      logic               r_in;
      logic               r_out;
      logic               ba_out;
      logic               c_out;
      logic               con_in;
      logic               in_port_out;
      logic               out_port_in;
      logic [ALUOP_W-1:0] alu_op;
   } ctrl_t;

   // Execute step after which the instruction is complete ("done")
   function automatic state_e last_step(input logic [OPC_W-1:0] opc);
      case (opc)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
         OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: last_step = S_T5;
         OP_LD, OP_ST:                     last_step = S_T7;
         OP_MUL, OP_DIV, OP_BR:            last_step = S_T6;
         OP_NEG, OP_NOT, OP_JAL:           last_step = S_T4;
         default:                          last_step = S_T3;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_output_decode.sv
// control_output_decode: purely combinational map from the current FSM state
// (and, during execute, the opcode) to the full strobe bundle.
module control_output_decode
   import control_sequencer_pkg::*;
(
   input  state_e           state,
   input  logic [OPC_W-1:0] opcode,
   input  logic             con_ff,
   output ctrl_t            ctrl
);

   // Strobe decode: one set of strobes per state/opcode step
   always_comb begin
      // NOTE: clearing the whole bundle first means any step not listed below
      // drives zeros instead of inferring a latch on the unassigned fields.
      ctrl     = '0;
      ctrl.run = state inside {S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7};
      case (state)
         S_F0: begin
            ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
         end
         S_F1: begin
            ctrl.z_low_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
         end
         S_F2: begin
            ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
         end
         S_T3: begin
            case (opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
               OP_ADDI, OP_ANDI, OP_ORI: begin
                  ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
               end
               OP_LD, OP_LDI, OP_ST: begin
                  ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
               end
               OP_MUL, OP_DIV: begin
                  ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
               end
               OP_NEG, OP_NOT: begin
                  ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                  ctrl.alu_op = ALUOP_W'(opcode);
               end
               OP_BR: begin
                  ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
               end
               OP_JR: begin
                  ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
               end
               OP_JAL: begin
                  // rb names the link register that receives the return PC
                  ctrl.pc_out = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1;
               end
               OP_IN: begin
                  ctrl.in_port_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
               end
               OP_OUT: begin
                  ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.out_port_in = 1'b1;
               end
               OP_MFHI: begin
                  ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
               end
               OP_MFLO: begin
                  ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
               end
               OP_NOP, OP_HALT: ;
               default: ;
            endcase
         end
         S_T4: begin
            case (opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                  ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                  ctrl.alu_op = ALUOP_W'(opcode);
               end
               OP_ADDI, OP_LD, OP_LDI, OP_ST: begin
                  ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = ALUOP_W'(OP_ADD);
               end
               OP_ANDI: begin
                  ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = ALUOP_W'(OP_AND);
               end
               OP_ORI: begin
                  ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = ALUOP_W'(OP_OR);
               end
               OP_MUL, OP_DIV: begin
                  ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                  ctrl.alu_op = ALUOP_W'(opcode);
               end
               OP_NEG, OP_NOT: begin
                  ctrl.z_low_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
               end
               OP_BR: begin
                  ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
               end
               OP_JAL: begin
                  ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
               OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                  ctrl.z_low_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
               end
               OP_LD, OP_ST: begin
                  ctrl.z_low_out = 1'b1; ctrl.mar_in = 1'b1;
               end
               OP_MUL, OP_DIV: begin
                  ctrl.z_low_out = 1'b1; ctrl.lo_in = 1'b1;
               end
               OP_BR: begin
                  ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = ALUOP_W'(OP_ADD);
               end
               default: ;
            endcase
         end
         S_T6: begin
            case (opcode)
               OP_LD: begin
                  ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
               end
               OP_ST: begin
                  // MDR is loaded from the register bus, not from memory
                  ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
               end
               OP_MUL, OP_DIV: begin
                  ctrl.z_high_out = 1'b1; ctrl.hi_in = 1'b1;
               end
               OP_BR: begin
                  ctrl.z_low_out = con_ff; ctrl.pc_in = con_ff;
               end
               default: ;
            endcase
         end
         S_T7: begin
            case (opcode)
               OP_LD: begin
                  ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
               end
               OP_ST: ctrl.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM that sequences fetch (F0-F2) and per-opcode
// execute (T3-T7) for the RISC datapath. Holds the state register and the
// next-state logic; strobe decode lives in control_output_decode.
// Build option: define SINGLE_STEP_EN to add the step input and a WAIT state
// entered after every completed instruction.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        stop,
`ifdef SINGLE_STEP_EN
   input  logic        step,
`endif
   output logic        Run,
   output logic        PCout,
   output logic        IncPC,
   output logic        PCin,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        Write,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic        CONin,
   output logic        InPortout,
   output logic        OutPortin,
   output logic [ALUOP_W-1:0] alu_op
);

   state_e           state_q, state_d;
   state_e           done_state;
   logic [OPC_W-1:0] opcode;
   logic             unused_ir;
   ctrl_t            ctrl;

   assign opcode    = IR[IR_OPC_MSB:IR_OPC_LSB];
   assign unused_ir = ^IR[IR_OPC_LSB-1:0];

   // State register with synchronous reset into RST
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      if (reset) state_q <= S_RST;
      else       state_q <= state_d;
   end

`ifdef SINGLE_STEP_EN
   logic step_q, step_d, step_prev_q, step_prev_d, step_rise;

   // Step input register and its one-cycle-delayed copy for edge detection
   always_comb begin
      step_d      = step;
      step_prev_d = step_q;
   end

   // Step edge-detect flops
   always_ff @(posedge clock) begin
      if (reset) begin
         step_q      <= 1'b0;
         step_prev_q <= 1'b0;
      end else begin
         step_q      <= step_d;
         step_prev_q <= step_prev_d;
      end
   end

   assign step_rise  = step_q & ~step_prev_q;
   assign done_state = S_WAIT;
`else
   assign done_state = S_F0;
`endif

   // Next-state: fixed fetch, per-opcode execute length, stop at boundary
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST: state_d = S_F0;
         S_F0:  state_d = S_F1;
         S_F1:  state_d = S_F2;
         S_F2:  state_d = S_T3;
         S_T3, S_T4, S_T5, S_T6, S_T7: begin
            if (opcode == OP_HALT) begin
               state_d = S_HALT;
            end else if (state_q == last_step(opcode)) begin
               state_d = stop ? S_HALT : done_state;
            end else begin
               case (state_q)
                  S_T3:    state_d = S_T4;
                  S_T4:    state_d = S_T5;
                  S_T5:    state_d = S_T6;
                  S_T6:    state_d = S_T7;
                  default: state_d = S_F0;
               endcase
            end
         end
         S_HALT: state_d = S_HALT;
`ifdef SINGLE_STEP_EN
         S_WAIT: begin
            if (stop)           state_d = S_HALT;
            else if (step_rise) state_d = S_F0;
         end
`endif
         default: state_d = S_RST;
      endcase
   end

   control_output_decode u_decode (
      .state  (state_q),
      .opcode (opcode),
      .con_ff (CON_FF),
      .ctrl   (ctrl)
   );

   // Output mapping from the decoded bundle onto the named strobe ports
   always_comb begin
      Run       = ctrl.run;
      PCout     = ctrl.pc_out;
      IncPC     = ctrl.inc_pc;
      PCin      = ctrl.pc_in;
      MARin     = ctrl.mar_in;
      MDRin     = ctrl.mdr_in;
      MDRout    = ctrl.mdr_out;
      Read      = ctrl.read;
      Write     = ctrl.write;
      IRin      = ctrl.ir_in;
      Yin       = ctrl.y_in;
      Zin       = ctrl.z_in;
      Zlowout   = ctrl.z_low_out;
      Zhighout  = ctrl.z_high_out;
      HIin      = ctrl.hi_in;
      LOin      = ctrl.lo_in;
      HIout     = ctrl.hi_out;
      LOout     = ctrl.lo_out;
      Gra       = ctrl.gra;
      Grb       = ctrl.grb;
      Grc       = ctrl.grc;
      Rin       = ctrl.r_in;
      Rout      = ctrl.r_out;
      BAout     = ctrl.ba_out;
      Cout      = ctrl.c_out;
      CONin     = ctrl.con_in;
      InPortout = ctrl.in_port_out;
      OutPortin = ctrl.out_port_in;
      alu_op    = ctrl.alu_op;
   end

endmodule
